// File: rtl/axi_lite_regfile.sv
// AXI4-Lite control/status register bank: host-writable control registers
// driven out to core logic, plus core-driven status registers readable by the host.
module axi_lite_regfile #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int C_NUM_RW_REGS      = 8,
   parameter int C_NUM_RO_REGS      = 4
) (
   input  logic                                      S_AXI_ACLK,
   input  logic                                      S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
   input  logic [2:0]                                S_AXI_AWPROT,
   input  logic                                      S_AXI_AWVALID,
   output logic                                      S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
   input  logic                                      S_AXI_WVALID,
   output logic                                      S_AXI_WREADY,
   output logic [1:0]                                S_AXI_BRESP,
   output logic                                      S_AXI_BVALID,
   input  logic                                      S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
   input  logic [2:0]                                S_AXI_ARPROT,
   input  logic                                      S_AXI_ARVALID,
   output logic                                      S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_RDATA,
   output logic [1:0]                                S_AXI_RRESP,
   output logic                                      S_AXI_RVALID,
   input  logic                                      S_AXI_RREADY,
   output logic [C_NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] rw_regs_o,
   output logic [C_NUM_RW_REGS-1:0]                  wr_pulse_o,
   input  logic [C_NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_regs_i,
   output logic [C_NUM_RO_REGS-1:0]                  rd_pulse_o
);

   localparam int DW  = C_S_AXI_DATA_WIDTH;
   localparam int SB  = DW / 8;
   localparam int LSB = $clog2(SB);
   localparam int IW  = C_S_AXI_ADDR_WIDTH - LSB;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // One extra bit so the region limits fit even when the map fills the address space.
   localparam logic [IW:0] RW_END = (IW+1)'(C_NUM_RW_REGS);
   localparam logic [IW:0] RO_END = (IW+1)'(C_NUM_RW_REGS + C_NUM_RO_REGS);

   function automatic logic [1:0] decode_resp(input logic [IW-1:0] idx, input logic is_write);
      logic [IW:0] x;
      x = {1'b0, idx};
      if (x < RW_END)
         return RESP_OKAY;
      else if (x < RO_END)
         return is_write ? RESP_SLVERR : RESP_OKAY;
      else
         return RESP_DECERR;
   endfunction

   logic                              ready_en;
   logic                              aw_held;
   logic                              w_held;
   logic [IW-1:0]                     awaddr_q;
   logic [DW-1:0]                     wdata_q;
   logic [SB-1:0]                     wstrb_q;
   logic                              bvalid_q;
   logic [1:0]                        bresp_q;
   logic                              rvalid_q;
   logic [1:0]                        rresp_q;
   logic [DW-1:0]                     rdata_q;
   logic [C_NUM_RW_REGS-1:0][DW-1:0]  rw_q;
   logic [C_NUM_RW_REGS-1:0]          wr_pulse_q;
   logic [C_NUM_RO_REGS-1:0]          rd_pulse_q;

   logic                              aw_fire;
   logic                              w_fire;
   logic                              ar_fire;
   logic                              commit;
   logic [IW-1:0]                     wr_idx;
   logic [DW-1:0]                     wr_data;
   logic [SB-1:0]                     wr_strb;
   logic [IW-1:0]                     ar_idx;
   logic [C_NUM_RW_REGS-1:0]          wr_sel;
   logic [C_NUM_RO_REGS-1:0]          rd_sel;
   logic [DW-1:0]                     rd_word;
   logic                              unused_bits;

   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

   // READY is held low until the first edge after reset release.
   assign S_AXI_AWREADY = ready_en & ~aw_held & ~bvalid_q;
   assign S_AXI_WREADY  = ready_en & ~w_held & ~bvalid_q;
   assign S_AXI_ARREADY = ready_en & ~rvalid_q;

   assign aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_fire  = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_fire = S_AXI_ARVALID & S_AXI_ARREADY;
   assign commit  = (aw_held | aw_fire) & (w_held | w_fire);

   assign wr_idx  = aw_held ? awaddr_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
   assign wr_data = w_held ? wdata_q : S_AXI_WDATA;
   assign wr_strb = w_held ? wstrb_q : S_AXI_WSTRB;
   assign ar_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];

   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < C_NUM_RW_REGS; i++)
         wr_sel[i] = commit & ({1'b0, wr_idx} == (IW+1)'(i));
   end

   always_comb begin
      rd_word = '0;
      rd_sel  = '0;
      for (int i = 0; i < C_NUM_RW_REGS; i++)
         if ({1'b0, ar_idx} == (IW+1)'(i))
            rd_word = rw_q[i];
      for (int j = 0; j < C_NUM_RO_REGS; j++)
         if ({1'b0, ar_idx} == (IW+1)'(C_NUM_RW_REGS + j)) begin
            rd_word   = ro_regs_i[j*DW +: DW];
            rd_sel[j] = 1'b1;
         end
   end

   // Write channel: hold whichever of AW/W arrives first until its partner shows up.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         ready_en   <= 1'b0;
         aw_held    <= 1'b0;
         w_held     <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         rw_q       <= '0;
      end else begin
         ready_en   <= 1'b1;
         wr_pulse_q <= wr_sel;
         if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= decode_resp(wr_idx, 1'b1);
         end else begin
            if (aw_fire) begin
               aw_held  <= 1'b1;
               awaddr_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
            end
            if (w_fire) begin
               w_held  <= 1'b1;
               wdata_q <= S_AXI_WDATA;
               wstrb_q <= S_AXI_WSTRB;
            end
            if (S_AXI_BREADY)
               bvalid_q <= 1'b0;
         end
         for (int i = 0; i < C_NUM_RW_REGS; i++)
            if (wr_sel[i])
               for (int k = 0; k < SB; k++)
                  if (wr_strb[k])
                     rw_q[i][k*8 +: 8] <= wr_data[k*8 +: 8];
      end
   end

   // Read channel: response captured at the AR handshake and held until RREADY.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
         rd_pulse_q <= '0;
      end else begin
         rd_pulse_q <= ar_fire ? rd_sel : '0;
         if (ar_fire) begin
            rvalid_q <= 1'b1;
            rresp_q  <= decode_resp(ar_idx, 1'b0);
            rdata_q  <= rd_word;
         end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RRESP  = rresp_q;
   assign S_AXI_RDATA  = rdata_q;
   assign rw_regs_o    = rw_q;
   assign wr_pulse_o   = wr_pulse_q;
   assign rd_pulse_o   = rd_pulse_q;

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
- Parametrised AXI4-Lite slave that replaces the empty top-level shell with a working control/status register bank.
- Exposes C_NUM_RW_REGS host-writable control registers to core logic and C_NUM_RO_REGS core-driven status registers to the host.
- Adds byte-strobe writes, per-register write/read strobes to core logic, and error responses for illegal or unmapped accesses.
- Sits between the AXI interconnect and the vscale core/peripheral glue.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; 32 or 64 only.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width; must cover (C_NUM_RW_REGS+C_NUM_RO_REGS)*DW/8 bytes.
- C_NUM_RW_REGS, 8, count of read/write control registers (>=1).
- C_NUM_RO_REGS, 4, count of read-only status registers (>=0).

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR_WIDTH/3/1  write address channel; AWPROT ignored.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA/WSTRB/WVALID  in  DW/DW/8/1  write data channel.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP/BVALID  out  2/1  write response.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR_WIDTH/3/1  read address channel; ARPROT ignored.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA/RRESP/RVALID  out  DW/2/1  read data channel.
- S_AXI_RREADY  in  1  read data ready.
- rw_regs_o  out  C_NUM_RW_REGS*DW  flattened control registers; reg i at bits [i*DW +: DW].
- wr_pulse_o  out  C_NUM_RW_REGS  1-cycle pulse per control register written.
- ro_regs_i  in  C_NUM_RO_REGS*DW  flattened status inputs, sampled at read.
- rd_pulse_o  out  C_NUM_RO_REGS  1-cycle pulse per status register read (for clear-on-read/pop).

Behaviour:
- Address decode:
  - idx = addr[ADDR_WIDTH-1:log2(DW/8)]; low byte-offset bits ignored.
  - idx < NUM_RW: control reg.
  - NUM_RW <= idx < NUM_RW+NUM_RO: status reg.
  - Otherwise: unmapped.
- Reset (async assert, sync release): all rw regs 0; AWREADY, WREADY, ARREADY, BVALID, RVALID 0; BRESP, RRESP, RDATA 0; all pulses 0.
  - Reset mid-transaction discards held address/data and pending responses immediately.
  - First READY rises on the first clock edge after release.
- Write path, state: aw_held, w_held, awaddr_q, wdata_q, wstrb_q.
  - AWREADY = ~aw_held & ~BVALID; WREADY = ~w_held & ~BVALID. Both are registered-state derived; no combinational path from VALID to READY.
  - AW and W accepted independently, in either order or the same cycle.
  - Commit edge = first edge where address (held or firing) and data (held or firing) are both available.
  - At commit: target reg updated bytewise (byte k written iff WSTRB[k]), wr_pulse_o[idx]=1 for one cycle, BVALID=1, held flags cleared.
  - Latency: AW and W handshaking in cycle 0 gives new reg value, pulse and BVALID all visible in cycle 1.
  - BRESP: OKAY (00) for control reg, including WSTRB=0 (no bytes change, pulse still fires); SLVERR (10) for status reg (no change, no pulse); DECERR (11) for unmapped (no change, no pulse).
  - BVALID/BRESP held until BREADY; new AW/W accepted only after B handshake. One outstanding write.
- Read path:
  - ARREADY = ~RVALID.
  - On AR handshake at edge N: RVALID=1, RDATA, RRESP and rd_pulse_o[idx] (status regs only) registered at edge N.
  - RDATA = control reg value, or ro_regs_i sampled in the AR cycle.
  - RRESP: OKAY for mapped, DECERR with RDATA=0 for unmapped.
  - RVALID/RDATA/RRESP stable until RREADY. One outstanding read.
- Read and write paths are fully independent.
  - Read and write commit on the same edge to the same control reg: read returns the pre-write value.
- wr_pulse_o and rd_pulse_o are strictly one cycle wide and at most one-hot each.

Test Plan:
- Reset released; AW=0x04, W=0xDEADBEEF, WSTRB=F presented together -> BVALID with BRESP=00 one cycle later; rw_regs_o[63:32]=0xDEADBEEF; wr_pulse_o=0x02 for 1 cycle.
- W with data 0x11223344, WSTRB=0x5 presented 3 cycles before AW=0x04 -> reg1 becomes 0xDE22BE44; WREADY low after W accepted until B handshake.
- ro_regs_i reg0=0xCAFEF00D, AR=0x20 (idx 8) with RREADY held low 4 cycles -> RVALID rises next cycle with RDATA=0xCAFEF00D, RRESP=00; values stable 4 cycles; ARREADY=0 throughout; rd_pulse_o=0x1 exactly once.
- Write to 0x20 -> BRESP=10, no pulse, no change. Write to 0x30 -> BRESP=11. Read of 0x30 -> RRESP=11, RDATA=0.
- Same edge: write 0x5 to reg2 while reading reg2 (old value 0x7) -> RDATA=0x7; subsequent read -> 0x5.
- Assert ARESETN low while BVALID=1 and RVALID=1 -> both drop immediately; rw_regs_o=0; after release a new write completes normally.
